contactor_sequencer: RTL

- Drives the pack contactors (negative main, precharge relay, positive main) from the enables and fault flag produced by the protection state machine.
- Enforces a fixed close order: negative main, precharge, positive main, then precharge relay open.
- Enforces a fixed open order: positive main, then negative main after a delay.
- Aborts safely on fault, request loss or precharge timeout. Sits between protection logic and the relay driver pins.

---
 rtl/contactor_sequencer_if.sv | 23 ++
 rtl/contactor_sequencer.sv | 111 +++++++++++
 2 files changed

// File: rtl/contactor_sequencer_if.sv
// rtl/contactor_sequencer_if.sv - protection-side enables in, contactor commands and status out
interface contactor_sequencer_if;
  logic       charge_en_fsm;
  logic       discharge_en_fsm;
  logic       system_fault;
  logic       precharge_ok;
  logic       neg_contactor;
  logic       precharge_relay;
  logic       pos_contactor;
  logic       ready;
  logic       precharge_fail;
  logic [2:0] seq_state;

  modport master (
    output charge_en_fsm, discharge_en_fsm, system_fault, precharge_ok,
    input  neg_contactor, precharge_relay, pos_contactor, ready, precharge_fail, seq_state
  );

  modport slave (
    input  charge_en_fsm, discharge_en_fsm, system_fault, precharge_ok,
    output neg_contactor, precharge_relay, pos_contactor, ready, precharge_fail, seq_state
  );
endinterface

// File: rtl/contactor_sequencer.sv
// rtl/contactor_sequencer.sv - pack contactor close/open sequencing with precharge timeout and fault lockout
module contactor_sequencer #(
  parameter int CNT_W             = 16,
  parameter int SETTLE_CYCLES     = 50,
  parameter int PRECHARGE_CYCLES  = 1000,
  parameter int OPEN_DELAY_CYCLES = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  contactor_sequencer_if.slave   ctl_if
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CLOSE_NEG = 3'd1;
  localparam logic [2:0] S_PRECHARGE = 3'd2;
  localparam logic [2:0] S_CLOSE_POS = 3'd3;
  localparam logic [2:0] S_CONNECTED = 3'd4;
  localparam logic [2:0] S_OPEN_POS  = 3'd5;
  localparam logic [2:0] S_LOCKOUT   = 3'd6;

  localparam logic [CNT_W-1:0] SETTLE_LAST    = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PRECHARGE_LAST = CNT_W'(PRECHARGE_CYCLES - 1);
  localparam logic [CNT_W-1:0] OPEN_LAST      = CNT_W'(OPEN_DELAY_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fail_q, fail_d;
  logic             req;
  logic [3:0]       outs;

  assign req = (ctl_if.charge_en_fsm | ctl_if.discharge_en_fsm) & ~ctl_if.system_fault;

  always_comb begin
    state_d = state_q;
    fail_d  = fail_q;
    case (state_q)
      S_IDLE: begin
        if (ctl_if.system_fault)  state_d = S_LOCKOUT;
        else if (req)             state_d = S_CLOSE_NEG;
      end
      S_CLOSE_NEG: begin
        if (ctl_if.system_fault)        state_d = S_LOCKOUT;
        else if (!req)                  state_d = S_IDLE;
        else if (cnt_q == SETTLE_LAST)  state_d = S_PRECHARGE;
      end
      S_PRECHARGE: begin
        // precharge_ok is checked before the timeout so it wins on the last cycle
        if (ctl_if.system_fault)        state_d = S_LOCKOUT;
        else if (!req)                  state_d = S_OPEN_POS;
        else if (ctl_if.precharge_ok)   state_d = S_CLOSE_POS;
        else if (cnt_q == PRECHARGE_LAST) begin
          state_d = S_LOCKOUT;
          fail_d  = 1'b1;
        end
      end
      S_CLOSE_POS: begin
        if (ctl_if.system_fault)        state_d = S_LOCKOUT;
        else if (!req)                  state_d = S_OPEN_POS;
        else if (cnt_q == SETTLE_LAST)  state_d = S_CONNECTED;
      end
      S_CONNECTED: begin
        if (ctl_if.system_fault)        state_d = S_LOCKOUT;
        else if (!req)                  state_d = S_OPEN_POS;
      end
      S_OPEN_POS: begin
        if (ctl_if.system_fault)        state_d = S_LOCKOUT;
        else if (cnt_q == OPEN_LAST)    state_d = S_IDLE;
      end
      S_LOCKOUT:                        state_d = S_LOCKOUT;
      default:                          state_d = S_LOCKOUT;
    endcase
  end

  always_comb begin
    if (state_d != state_q)     cnt_d = '0;
    else if (cnt_q == '1)       cnt_d = cnt_q;
    else                        cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
    end
  end

  // Moore decode: {neg, precharge, pos, ready}
  always_comb begin
    case (state_q)
      S_CLOSE_NEG: outs = 4'b1000;
      S_PRECHARGE: outs = 4'b1100;
      S_CLOSE_POS: outs = 4'b1110;
      S_CONNECTED: outs = 4'b1011;
      S_OPEN_POS:  outs = 4'b1000;
      default:     outs = 4'b0000;
    endcase
  end

  assign ctl_if.neg_contactor   = outs[3];
  assign ctl_if.precharge_relay = outs[2];
  assign ctl_if.pos_contactor   = outs[1];
  assign ctl_if.ready           = outs[0];
  assign ctl_if.precharge_fail  = fail_q;
  assign ctl_if.seq_state       = state_q;

endmodule
